// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants and immediate decoders for the branch resolution unit.
package branch_resolve_unit_pkg;

    localparam logic [3:0] FUNC_JAL    = 4'b0111;
    localparam logic [3:0] FUNC_JALR   = 4'b0101;
    localparam logic [3:0] FUNC_BRANCH = 4'b0100;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Immediates come back as signed 32-bit values; callers size-cast to XLEN.
    function automatic logic signed [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic signed [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic signed [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/branch_resolve_unit_core.sv
// Combinational resolution: target, branch condition, mispredict and link value.
module branch_resolve_core
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [3:0]      func_i,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            pred_taken_i,
    input  logic [XLEN-1:0] pred_target_i,
    output logic            taken_o,
    output logic            mispredict_o,
    output logic            wb_req_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] next_pc_o,
    output logic [XLEN-1:0] link_o
);

    logic [XLEN-1:0] imm_i_x;
    logic [XLEN-1:0] imm_b_x;
    logic [XLEN-1:0] imm_j_x;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic            is_jal;
    logic            is_jalr;
    logic            is_br;
    logic            cond;
    logic            unused_opcode;

    assign imm_i_x       = XLEN'(imm_i(inst_i));
    assign imm_b_x       = XLEN'(imm_b(inst_i));
    assign imm_j_x       = XLEN'(imm_j(inst_i));
    assign unused_opcode = ^inst_i[6:0];

    always_comb begin
        is_jal   = (func_i == FUNC_JAL);
        is_jalr  = (func_i == FUNC_JALR);
        is_br    = (func_i == FUNC_BRANCH);
        cond     = 1'b0;
        case (inst_i[14:12])
            F3_BEQ:  cond = (rs1_i == rs2_i);
            F3_BNE:  cond = (rs1_i != rs2_i);
            F3_BLT:  cond = ($signed(rs1_i) <  $signed(rs2_i));
            F3_BGE:  cond = ($signed(rs1_i) >= $signed(rs2_i));
            F3_BLTU: cond = (rs1_i <  rs2_i);
            F3_BGEU: cond = (rs1_i >= rs2_i);
            default: cond = 1'b0;
        endcase

        jalr_sum = rs1_i + imm_i_x;
        if (is_jalr) begin
            target = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (is_jal) begin
            target = pc_i + imm_j_x;
        end else begin
            target = pc_i + imm_b_x;
        end

        taken_o   = is_jal | is_jalr | (is_br & cond);
        link_o    = pc_i + XLEN'(4);
        next_pc_o = taken_o ? target : link_o;
        // Unknown func codes never redirect, even when the frontend predicted taken.
        mispredict_o = (is_jal | is_jalr | is_br) &
                       ((taken_o != pred_taken_i) | (taken_o & (target != pred_target_i)));
        rd_o     = is_br ? 5'd0 : inst_i[11:7];
        wb_req_o = (is_jal | is_jalr) & (inst_i[11:7] != 5'd0);
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage back-pressured branch resolution unit (S1 operands, S2 result).
// Optional performance counters: define BRANCH_RESOLVE_PERF_CNT_EN.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int SID_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             issue_valid_i,
    output logic             issue_ready_o,
    input  logic [XLEN-1:0]  issue_pc_i,
    input  logic [31:0]      issue_inst_i,
    input  logic [SID_W-1:0] issue_sid_i,
    input  logic [3:0]       issue_func_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic             pred_taken_i,
    input  logic [XLEN-1:0]  pred_target_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [SID_W-1:0] res_sid_o,
    output logic             wb_en_o,
    output logic [4:0]       wb_rd_o,
    output logic [XLEN-1:0]  wb_value_o,
`ifdef BRANCH_RESOLVE_PERF_CNT_EN
    output logic [CNT_W-1:0] perf_resolved_o,
    output logic [CNT_W-1:0] perf_mispredict_o,
`endif
    output logic             redirect_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             actual_taken_o
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("branch_resolve_unit: XLEN must be 32 or 64");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("branch_resolve_unit: CNT_W must be positive");
    end

    logic             s1_valid_q, s1_valid_d;
    logic [XLEN-1:0]  s1_pc_q;
    logic [31:0]      s1_inst_q;
    logic [SID_W-1:0] s1_sid_q;
    logic [3:0]       s1_func_q;
    logic [XLEN-1:0]  s1_rs1_q;
    logic [XLEN-1:0]  s1_rs2_q;
    logic             s1_pred_taken_q;
    logic [XLEN-1:0]  s1_pred_target_q;

    logic             s2_valid_q, s2_valid_d;
    logic [SID_W-1:0] s2_sid_q;
    logic             s2_taken_q;
    logic             s2_mispredict_q;
    logic             s2_wb_req_q;
    logic [4:0]       s2_rd_q;
    logic [XLEN-1:0]  s2_next_pc_q;
    logic [XLEN-1:0]  s2_link_q;

    logic             core_taken;
    logic             core_mispredict;
    logic             core_wb_req;
    logic [4:0]       core_rd;
    logic [XLEN-1:0]  core_next_pc;
    logic [XLEN-1:0]  core_link;

    logic             s1_adv;
    logic             issue_fire;

    assign s1_adv        = s1_valid_q & (~s2_valid_q | res_ready_i);
    assign issue_ready_o = ~s1_valid_q | s1_adv;
    assign issue_fire    = issue_valid_i & issue_ready_o;

    branch_resolve_core #(
        .XLEN (XLEN)
    ) u_core (
        .func_i        (s1_func_q),
        .inst_i        (s1_inst_q),
        .pc_i          (s1_pc_q),
        .rs1_i         (s1_rs1_q),
        .rs2_i         (s1_rs2_q),
        .pred_taken_i  (s1_pred_taken_q),
        .pred_target_i (s1_pred_target_q),
        .taken_o       (core_taken),
        .mispredict_o  (core_mispredict),
        .wb_req_o      (core_wb_req),
        .rd_o          (core_rd),
        .next_pc_o     (core_next_pc),
        .link_o        (core_link)
    );

    // Flush wins over accept and drain; a handshake in the flush cycle is dropped.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (flush_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (issue_fire) begin
                s1_valid_d = 1'b1;
            end else if (s1_adv) begin
                s1_valid_d = 1'b0;
            end
            if (s1_adv) begin
                s2_valid_d = 1'b1;
            end else if (res_ready_i) begin
                s2_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q       <= 1'b0;
            s1_pc_q          <= '0;
            s1_inst_q        <= '0;
            s1_sid_q         <= '0;
            s1_func_q        <= '0;
            s1_rs1_q         <= '0;
            s1_rs2_q         <= '0;
            s1_pred_taken_q  <= 1'b0;
            s1_pred_target_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (issue_fire) begin
                s1_pc_q          <= issue_pc_i;
                s1_inst_q        <= issue_inst_i;
                s1_sid_q         <= issue_sid_i;
                s1_func_q        <= issue_func_i;
                s1_rs1_q         <= rs1_i;
                s1_rs2_q         <= rs2_i;
                s1_pred_taken_q  <= pred_taken_i;
                s1_pred_target_q <= pred_target_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q      <= 1'b0;
            s2_sid_q        <= '0;
            s2_taken_q      <= 1'b0;
            s2_mispredict_q <= 1'b0;
            s2_wb_req_q     <= 1'b0;
            s2_rd_q         <= '0;
            s2_next_pc_q    <= '0;
            s2_link_q       <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s1_adv) begin
                s2_sid_q        <= s1_sid_q;
                s2_taken_q      <= core_taken;
                s2_mispredict_q <= core_mispredict;
                s2_wb_req_q     <= core_wb_req;
                s2_rd_q         <= core_rd;
                s2_next_pc_q    <= core_next_pc;
                s2_link_q       <= core_link;
            end
        end
    end

    assign res_valid_o    = s2_valid_q;
    assign res_sid_o      = s2_sid_q;
    assign wb_en_o        = s2_valid_q & s2_wb_req_q;
    assign wb_rd_o        = s2_rd_q;
    assign wb_value_o     = s2_link_q;
    assign redirect_o     = s2_valid_q & s2_mispredict_q;
    assign redirect_pc_o  = s2_next_pc_q;
    assign actual_taken_o = s2_taken_q;

`ifdef BRANCH_RESOLVE_PERF_CNT_EN
    logic [CNT_W-1:0] perf_resolved_q;
    logic [CNT_W-1:0] perf_mispredict_q;

    // Counters track consumed results only and deliberately ignore flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_resolved_q   <= '0;
            perf_mispredict_q <= '0;
        end else if (s2_valid_q & res_ready_i) begin
            perf_resolved_q <= perf_resolved_q + CNT_W'(1);
            if (s2_mispredict_q) begin
                perf_mispredict_q <= perf_mispredict_q + CNT_W'(1);
            end
        end
    end

    assign perf_resolved_o   = perf_resolved_q;
    assign perf_mispredict_o = perf_mispredict_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed, table-driven bench for branch_resolve_unit (XLEN=64).
module tb_branch_resolve_unit;

    localparam int XLEN  = 64;
    localparam int SID_W = 5;
    localparam int CNT_W = 32;

    localparam logic [3:0] F_JAL  = 4'b0111;
    localparam logic [3:0] F_JALR = 4'b0101;
    localparam logic [3:0] F_BR   = 4'b0100;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush_i = 1'b0;
    logic             issue_valid_i = 1'b0;
    logic             issue_ready_o;
    logic [XLEN-1:0]  issue_pc_i = '0;
    logic [31:0]      issue_inst_i = '0;
    logic [SID_W-1:0] issue_sid_i = '0;
    logic [3:0]       issue_func_i = '0;
    logic [XLEN-1:0]  rs1_i = '0;
    logic [XLEN-1:0]  rs2_i = '0;
    logic             pred_taken_i = 1'b0;
    logic [XLEN-1:0]  pred_target_i = '0;
    logic             res_valid_o;
    logic             res_ready_i = 1'b1;
    logic [SID_W-1:0] res_sid_o;
    logic             wb_en_o;
    logic [4:0]       wb_rd_o;
    logic [XLEN-1:0]  wb_value_o;
    logic             redirect_o;
    logic [XLEN-1:0]  redirect_pc_o;
    logic             actual_taken_o;
`ifdef BRANCH_RESOLVE_PERF_CNT_EN
    logic [CNT_W-1:0] perf_resolved_o;
    logic [CNT_W-1:0] perf_mispredict_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(XLEN), .SID_W(SID_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .issue_valid_i  (issue_valid_i),
        .issue_ready_o  (issue_ready_o),
        .issue_pc_i     (issue_pc_i),
        .issue_inst_i   (issue_inst_i),
        .issue_sid_i    (issue_sid_i),
        .issue_func_i   (issue_func_i),
        .rs1_i          (rs1_i),
        .rs2_i          (rs2_i),
        .pred_taken_i   (pred_taken_i),
        .pred_target_i  (pred_target_i),
        .res_valid_o    (res_valid_o),
        .res_ready_i    (res_ready_i),
        .res_sid_o      (res_sid_o),
        .wb_en_o        (wb_en_o),
        .wb_rd_o        (wb_rd_o),
        .wb_value_o     (wb_value_o),
`ifdef BRANCH_RESOLVE_PERF_CNT_EN
        .perf_resolved_o   (perf_resolved_o),
        .perf_mispredict_o (perf_mispredict_o),
`endif
        .redirect_o     (redirect_o),
        .redirect_pc_o  (redirect_pc_o),
        .actual_taken_o (actual_taken_o)
    );

    typedef struct {
        string       name;
        logic [3:0]  func;
        logic [31:0] inst;
        logic [63:0] pc;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic        pt;
        logic [63:0] ptgt;
        logic        e_taken;
        logic        e_redir;
        logic        e_wb;
        logic [4:0]  e_rd;
        logic [63:0] e_rpc;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rd);
        return {imm, 5'd1, 3'b000, rd, 7'b1100111};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic vec_t mk(input string n, input logic [3:0] f, input logic [31:0] i,
                                input logic [63:0] pc, input logic [63:0] r1, input logic [63:0] r2,
                                input logic pt, input logic [63:0] ptg,
                                input logic et, input logic er, input logic ew,
                                input logic [4:0] erd, input logic [63:0] erpc);
        vec_t v;
        v.name = n; v.func = f; v.inst = i; v.pc = pc; v.rs1 = r1; v.rs2 = r2;
        v.pt = pt; v.ptgt = ptg; v.e_taken = et; v.e_redir = er; v.e_wb = ew;
        v.e_rd = erd; v.e_rpc = erpc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] f, input logic [31:0] i, input logic [63:0] pc,
                         input logic [63:0] r1, input logic [63:0] r2, input logic pt,
                         input logic [63:0] ptg, input logic [4:0] sid);
        issue_valid_i = 1'b1; issue_func_i = f; issue_inst_i = i; issue_pc_i = pc;
        rs1_i = r1; rs2_i = r2; pred_taken_i = pt; pred_target_i = ptg; issue_sid_i = sid;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk("beq_taken",   F_BR,   enc_b(13'h0010, 3'b000), 64'h1000, 64'd5, 64'd5, 1'b0, 64'h0,
                      1'b1, 1'b1, 1'b0, 5'd0, 64'h1010);
        vecs[1]  = mk("blt_signed",  F_BR,   enc_b(13'h1FF8, 3'b100), 64'h2000, ONES, 64'd1, 1'b1, 64'h1FF8,
                      1'b1, 1'b0, 1'b0, 5'd0, 64'h1FF8);
        vecs[2]  = mk("bltu",        F_BR,   enc_b(13'h1FF8, 3'b110), 64'h2000, ONES, 64'd1, 1'b1, 64'h1FF8,
                      1'b0, 1'b1, 1'b0, 5'd0, 64'h2004);
        vecs[3]  = mk("jalr_bit0",   F_JALR, enc_i(12'h000, 5'd1), 64'h3000, 64'h2003, 64'd0, 1'b1, 64'h2002,
                      1'b1, 1'b0, 1'b1, 5'd1, 64'h2002);
        vecs[4]  = mk("jal_rd0",     F_JAL,  enc_j(21'h1FFF00, 5'd0), 64'h4000, 64'd0, 64'd0, 1'b0, 64'h0,
                      1'b1, 1'b1, 1'b0, 5'd0, 64'h3F00);
        vecs[5]  = mk("jal_rd5",     F_JAL,  enc_j(21'h000800, 5'd5), 64'h5000, 64'd0, 64'd0, 1'b1, 64'h5800,
                      1'b1, 1'b0, 1'b1, 5'd5, 64'h5800);
        vecs[6]  = mk("bne_nt",      F_BR,   enc_b(13'h0020, 3'b001), 64'h6000, 64'd3, 64'd3, 1'b0, 64'h0,
                      1'b0, 1'b0, 1'b0, 5'd0, 64'h6004);
        vecs[7]  = mk("bge_tgt_bad", F_BR,   enc_b(13'h0040, 3'b101), 64'h7000, 64'hFFFF_FFFF_FFFF_FFFB,
                      64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 64'h7044, 1'b1, 1'b1, 1'b0, 5'd0, 64'h7040);
        vecs[8]  = mk("bgeu_nt",     F_BR,   enc_b(13'h0040, 3'b111), 64'h8000, 64'd1, ONES, 1'b0, 64'h0,
                      1'b0, 1'b0, 1'b0, 5'd0, 64'h8004);
        vecs[9]  = mk("f3_reserved", F_BR,   enc_b(13'h0040, 3'b010), 64'h9000, 64'd0, 64'd0, 1'b1, 64'h9040,
                      1'b0, 1'b1, 1'b0, 5'd0, 64'h9004);
        vecs[10] = mk("func_other",  4'b0000, enc_j(21'h000010, 5'd3), 64'hA000, 64'd0, 64'd0, 1'b1, 64'hA010,
                      1'b0, 1'b0, 1'b0, 5'd3, 64'hA004);
        vecs[11] = mk("jalr_wrap",   F_JALR, enc_i(12'h020, 5'd2), 64'hB000, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0,
                      1'b1, 64'h10, 1'b1, 1'b0, 1'b1, 5'd2, 64'h10);
        vecs[12] = mk("jalr_negimm", F_JALR, enc_i(12'hFFF, 5'd0), 64'hC000, 64'h100, 64'd0, 1'b0, 64'h0,
                      1'b1, 1'b1, 1'b0, 5'd0, 64'hFE);
        vecs[13] = mk("jal_pc_wrap", F_JAL,  enc_j(21'h000020, 5'd1), 64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 64'd0,
                      1'b1, 64'h10, 1'b1, 1'b0, 1'b1, 5'd1, 64'h10);

        // Reset state
        #12;
        chk("rst_issue_ready", issue_ready_o, 1);
        chk("rst_res_valid", res_valid_o, 0);
        chk("rst_redirect", redirect_o, 0);
        chk("rst_wb_en", wb_en_o, 0);
        chk("rst_redirect_pc", redirect_pc_o, 0);
        chk("rst_taken", actual_taken_o, 0);
        chk("rst_wb_value", wb_value_o, 0);
        chk("rst_sid", res_sid_o, 0);
        @(negedge clk); rst_n = 1'b1;

        // Table: one op at a time, res_ready high
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            drive(vecs[k].func, vecs[k].inst, vecs[k].pc, vecs[k].rs1, vecs[k].rs2,
                  vecs[k].pt, vecs[k].ptgt, 5'(k + 1));
            @(posedge clk); #1;
            issue_valid_i = 1'b0;
            chk({vecs[k].name, "_latency"}, res_valid_o, 0);
            @(posedge clk); #1;
            chk({vecs[k].name, "_valid"}, res_valid_o, 1);
            chk({vecs[k].name, "_sid"}, res_sid_o, 64'(k + 1));
            chk({vecs[k].name, "_taken"}, actual_taken_o, vecs[k].e_taken);
            chk({vecs[k].name, "_redirect"}, redirect_o, vecs[k].e_redir);
            chk({vecs[k].name, "_redirect_pc"}, redirect_pc_o, vecs[k].e_rpc);
            chk({vecs[k].name, "_wb_en"}, wb_en_o, vecs[k].e_wb);
            chk({vecs[k].name, "_wb_rd"}, wb_rd_o, vecs[k].e_rd);
            chk({vecs[k].name, "_wb_value"}, wb_value_o, vecs[k].pc + 64'd4);
        end
        @(negedge clk);
        @(posedge clk); #1;
        chk("drain_idle", res_valid_o, 0);

        // Back-to-back issue under back-pressure
        @(negedge clk);
        res_ready_i = 1'b0;
        drive(F_BR, enc_b(13'h0010, 3'b000), 64'h100, 64'd1, 64'd2, 1'b0, 64'h0, 5'd1);
        @(posedge clk); #1;
        chk("bp_accept1_ready", issue_ready_o, 1);
        @(negedge clk);
        drive(F_BR, enc_b(13'h0010, 3'b000), 64'h200, 64'd1, 64'd2, 1'b0, 64'h0, 5'd2);
        @(posedge clk); #1;
        chk("bp_ready_drop", issue_ready_o, 0);
        chk("bp_sid1", res_sid_o, 1);
        @(negedge clk);
        drive(F_BR, enc_b(13'h0010, 3'b000), 64'h300, 64'd1, 64'd2, 1'b0, 64'h0, 5'd3);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", res_valid_o, 1);
            chk("bp_hold_sid", res_sid_o, 1);
            chk("bp_hold_pc", redirect_pc_o, 64'h104);
            chk("bp_hold_ready", issue_ready_o, 0);
        end
        @(negedge clk);
        res_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("bp_drain_sid2", res_sid_o, 2);
        chk("bp_drain_pc2", redirect_pc_o, 64'h204);
        @(negedge clk);
        issue_valid_i = 1'b0;
        @(posedge clk); #1;
        chk("bp_drain_sid3", res_sid_o, 3);
        chk("bp_drain_pc3", redirect_pc_o, 64'h304);
        chk("bp_drain_valid3", res_valid_o, 1);
        @(posedge clk); #1;
        chk("bp_empty", res_valid_o, 0);

        // Flush with S1 and S2 both occupied
        @(negedge clk);
        res_ready_i = 1'b0;
        drive(F_BR, enc_b(13'h0008, 3'b000), 64'h700, 64'd4, 64'd4, 1'b0, 64'h0, 5'd7);
        @(negedge clk);
        drive(F_BR, enc_b(13'h0008, 3'b000), 64'h800, 64'd4, 64'd4, 1'b0, 64'h0, 5'd8);
        @(posedge clk); #1;
        chk("fl_pre_valid", res_valid_o, 1);
        chk("fl_pre_sid", res_sid_o, 7);
        chk("fl_pre_redirect", redirect_o, 1);
        @(negedge clk);
        drive(F_BR, enc_b(13'h0008, 3'b000), 64'h900, 64'd4, 64'd4, 1'b0, 64'h0, 5'd9);
        flush_i = 1'b1;
        @(posedge clk); #1;
        chk("fl_valid", res_valid_o, 0);
        chk("fl_redirect", redirect_o, 0);
        chk("fl_ready", issue_ready_o, 1);
        @(negedge clk);
        flush_i = 1'b0; issue_valid_i = 1'b0; res_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("fl_no_result", res_valid_o, 0);
        end
`ifdef BRANCH_RESOLVE_PERF_CNT_EN
        chk("perf_resolved", perf_resolved_o, 17);
        chk("perf_mispredict", perf_mispredict_o, 6);
`endif

        // Handshake coinciding with flush is dropped
        @(negedge clk);
        drive(F_JAL, enc_j(21'h000010, 5'd1), 64'hD000, 64'd0, 64'd0, 1'b0, 64'h0, 5'd10);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0; issue_valid_i = 1'b0;
        @(posedge clk); #1;
        chk("fl_drop_valid", res_valid_o, 0);
        chk("fl_drop_wb_en", wb_en_o, 0);
`ifdef BRANCH_RESOLVE_PERF_CNT_EN
        chk("perf_resolved_kept", perf_resolved_o, 17);
`endif

        // Asynchronous reset mid-operation
        @(negedge clk);
        res_ready_i = 1'b0;
        drive(F_JAL, enc_j(21'h000010, 5'd1), 64'hE000, 64'd0, 64'd0, 1'b0, 64'h0, 5'd11);
        @(negedge clk);
        issue_valid_i = 1'b0;
        @(posedge clk); #1;
        chk("ar_pre_valid", res_valid_o, 1);
        chk("ar_pre_sid", res_sid_o, 11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", res_valid_o, 0);
        chk("ar_sid", res_sid_o, 0);
        chk("ar_wb_en", wb_en_o, 0);
        chk("ar_redirect_pc", redirect_pc_o, 0);
        chk("ar_ready", issue_ready_o, 1);
`ifdef BRANCH_RESOLVE_PERF_CNT_EN
        chk("ar_perf", perf_resolved_o, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1; res_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("ar_post_valid", res_valid_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
